// File: rtl/key_mem_write_pkg.sv
// Shared constants for the key-triggered memory writer: FSM encoding and debounce length.
// KEY_MEM_WRITE_FAST_SIM_EN forces the effective debounce length to FAST_SIM_DEBOUNCE.
// No datapath here; consumed by key_mem_write and key_debounce.
package key_mem_write_pkg;

   localparam logic [1:0] ST_IDLE       = 2'd0;
   localparam logic [1:0] ST_PRESS_DB   = 2'd1;
   localparam logic [1:0] ST_WRITE      = 2'd2;
   localparam logic [1:0] ST_RELEASE_DB = 2'd3;

   localparam int unsigned FAST_SIM_DEBOUNCE = 4;
   localparam int unsigned SW_WIDTH          = 18;

   // A zero length would leave the counter without a terminal value, so clamp to 1.
   function automatic int unsigned eff_debounce(input int unsigned cycles);
`ifdef KEY_MEM_WRITE_FAST_SIM_EN
      eff_debounce = (cycles == 0) ? FAST_SIM_DEBOUNCE : FAST_SIM_DEBOUNCE;
`else
      eff_debounce = (cycles == 0) ? 1 : cycles;
`endif
   endfunction

endpackage

// File: rtl/key_debounce.sv
// Two-flop synchronizer for the raw key plus a counter of cycles since the last clear.
// Latency: level_out lags level_in by 2 clocks; stable_out on the LEN-th uncleared cycle.
// No backpressure; the owner holds clear whenever the level is not the one being timed.
module key_debounce #(
   parameter int unsigned LEN = 4
) (
   input  logic clk_50,
   input  logic rst_n,
   input  logic level_in,
   input  logic clear,
   output logic level_out,
   output logic stable_out
);

   localparam int CW = (LEN > 1) ? $clog2(LEN) : 1;
   localparam logic [CW-1:0] CNT_LAST = CW'(LEN - 1);

   logic          sync_q1;
   logic          sync_q2;
   logic [CW-1:0] cnt_q;

   // Released is the safe idle level, so the synchronizer resets high.
   always_ff @(posedge clk_50 or negedge rst_n) begin
      if (!rst_n) begin
         sync_q1 <= 1'b1;
         sync_q2 <= 1'b1;
      end else begin
         sync_q1 <= level_in;
         sync_q2 <= sync_q1;
      end
   end

   always_ff @(posedge clk_50 or negedge rst_n) begin
      if (!rst_n) begin
         cnt_q <= '0;
      end else if (clear) begin
         cnt_q <= '0;
      end else if (cnt_q != CNT_LAST) begin
         cnt_q <= cnt_q + CW'(1);
      end
   end

   assign level_out  = sync_q2;
   assign stable_out = !clear && (cnt_q == CNT_LAST);

endmodule

// File: rtl/key_mem_write.sv
// Debounced key press stores sw_in (zero-extended) at the next word address; KEY_MEM_WRITE_FAST_SIM_EN sets debounce to 4.
// Latency: one-cycle write pulse debounce+2 clocks after the key is first sampled low.
// No backpressure: the memory must accept the write in its single enable cycle.
module key_mem_write
   import key_mem_write_pkg::*;
#(
   parameter int unsigned ADDR_WIDTH      = 32,
   parameter int unsigned DATA_WIDTH      = 32,
   parameter int unsigned DEBOUNCE_CYCLES = 1000000,
   parameter int unsigned ADDR_LIMIT      = 256
) (
   input  logic                  clk_50,
   input  logic                  rst_n,
   input  logic                  write_in,
   input  logic [SW_WIDTH-1:0]   sw_in,
   output logic [ADDR_WIDTH-1:0] addr_out,
   output logic [DATA_WIDTH-1:0] data_out,
   output logic                  data_mem_wr_en_out,
   output logic                  busy_out
);

   localparam int unsigned           DB_LEN    = eff_debounce(DEBOUNCE_CYCLES);
   localparam logic [ADDR_WIDTH-1:0] ADDR_LAST = ADDR_WIDTH'(ADDR_LIMIT - 1);

   logic [1:0]            state_q;
   logic [1:0]            state_d;
   logic [ADDR_WIDTH-1:0] addr_q;
   logic [DATA_WIDTH-1:0] data_q;
   logic                  key_level;
   logic                  key_pressed;
   logic                  db_clear;
   logic                  db_stable;
   logic                  capture;

   key_debounce #(
      .LEN (DB_LEN)
   ) u_debounce (
      .clk_50     (clk_50),
      .rst_n      (rst_n),
      .level_in   (write_in),
      .clear      (db_clear),
      .level_out  (key_level),
      .stable_out (db_stable)
   );

   assign key_pressed = !key_level;

   // The shared counter only runs while the level matches what the current state is timing.
   always_comb begin
      state_d  = state_q;
      db_clear = 1'b1;
      case (state_q)
         ST_IDLE: begin
            if (key_pressed) begin
               state_d = ST_PRESS_DB;
            end
         end
         ST_PRESS_DB: begin
            db_clear = !key_pressed;
            if (!key_pressed) begin
               state_d = ST_IDLE;
            end else if (db_stable) begin
               state_d = ST_WRITE;
            end
         end
         ST_WRITE: begin
            state_d = ST_RELEASE_DB;
         end
         ST_RELEASE_DB: begin
            db_clear = key_pressed;
            if (!key_pressed && db_stable) begin
               state_d = ST_IDLE;
            end
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   assign capture = (state_q == ST_PRESS_DB) && key_pressed && db_stable;

   always_ff @(posedge clk_50 or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= ST_IDLE;
         addr_q  <= '0;
         data_q  <= '0;
      end else begin
         state_q <= state_d;
         if (capture) begin
            data_q <= DATA_WIDTH'(sw_in);
         end
         if (state_q == ST_WRITE) begin
            addr_q <= (addr_q == ADDR_LAST) ? '0 : addr_q + ADDR_WIDTH'(1);
         end
      end
   end

   // Enable decodes straight from the state flop so reset removes it without a clock.
   assign data_mem_wr_en_out = (state_q == ST_WRITE);
   assign busy_out           = (state_q != ST_IDLE);
   assign addr_out           = addr_q;
   assign data_out           = data_q;

endmodule

// File: tb/tb_key_mem_write.sv
// Bench for key_mem_write: run-length reference model over the synchronized key trace.
`timescale 1ns/1ps
module tb_key_mem_write;

   localparam int LEN   = 4;
   localparam int LIMIT = 4;
   localparam int MAXC  = 512;

   logic        clk_50   = 1'b0;
   logic        rst_n    = 1'b1;
   logic        write_in = 1'b1;
   logic [17:0] sw_in    = '0;
   logic [31:0] addr_out;
   logic [31:0] data_out;
   logic        wr_en;
   logic        busy;

   key_mem_write #(
      .ADDR_WIDTH      (32),
      .DATA_WIDTH      (32),
      .DEBOUNCE_CYCLES (LEN),
      .ADDR_LIMIT      (LIMIT)
   ) dut (
      .clk_50             (clk_50),
      .rst_n              (rst_n),
      .write_in           (write_in),
      .sw_in              (sw_in),
      .addr_out           (addr_out),
      .data_out           (data_out),
      .data_mem_wr_en_out (wr_en),
      .busy_out           (busy)
   );

   always #10 clk_50 = ~clk_50;

   int          n_cmp = 0;
   int          n_bad = 0;
   int          m_addr = 0;
   logic [31:0] m_data = '0;
   int          e_writes;

   logic        wave [MAXC];
   logic [17:0] swv  [MAXC];
   logic        g_wr [MAXC];
   logic        g_busy [MAXC];
   logic [31:0] g_addr [MAXC];
   logic [31:0] g_data [MAXC];
   logic        e_wr [MAXC];
   logic        e_busy [MAXC];
   logic [31:0] e_addr [MAXC];
   logic [31:0] e_data [MAXC];

   // Pressed level as seen after the two-flop synchronizer.
   function automatic logic lvl(input int c);
      return (c >= 2) ? !wave[c-2] : 1'b0;
   endfunction

   task automatic set_wave(input int from, input int to, input logic v);
      for (int c = from; c < to; c++) wave[c] = v;
   endtask

   // Scan press/release runs: a write needs LEN pressed cycles after idle detection,
   // and idle returns only after LEN consecutive released cycles.
   task automatic build_model(input int n);
      int pos, t, j, run, c2;
      for (int c = 0; c < n; c++) begin e_wr[c] = 1'b0; e_busy[c] = 1'b0; end
      pos = 0;
      while (pos < n) begin
         if (!lvl(pos)) begin
            pos++;
         end else begin
            t = pos;
            j = 1;
            while (j <= LEN && t + j < n && lvl(t + j)) j++;
            if (j <= LEN) begin
               for (int b = t + 1; b <= t + j && b < n; b++) e_busy[b] = 1'b1;
               pos = t + j + 1;
            end else begin
               if (t + LEN + 1 < n) e_wr[t+LEN+1] = 1'b1;
               run = 0;
               c2  = t + LEN + 2;
               while (c2 < n && run < LEN) begin
                  run = lvl(c2) ? 0 : run + 1;
                  c2++;
               end
               for (int b = t + 1; b < c2 && b < n; b++) e_busy[b] = 1'b1;
               pos = c2;
            end
         end
      end
      e_writes = 0;
      for (int c = 0; c < n; c++) begin
         if (e_wr[c]) begin
            m_data = {14'd0, swv[c-1]};
            e_writes++;
         end
         e_data[c] = m_data;
         e_addr[c] = 32'(m_addr);
         if (e_wr[c]) m_addr = (m_addr + 1) % LIMIT;
      end
   endtask

   task automatic run_trace(input int n);
      for (int c = 0; c < n; c++) begin
         @(posedge clk_50); #1;
         write_in = wave[c];
         sw_in    = swv[c];
         @(negedge clk_50);
         g_wr[c]   = wr_en;
         g_busy[c] = busy;
         g_addr[c] = addr_out;
         g_data[c] = data_out;
      end
      build_model(n);
   endtask

   task automatic pulse_reset();
      @(negedge clk_50);
      write_in = 1'b1;
      rst_n    = 1'b0;
      @(negedge clk_50);
      rst_n    = 1'b1;
      m_addr   = 0;
      m_data   = '0;
      repeat (3) @(negedge clk_50);
   endtask

   task automatic test_reset();
      #3 rst_n = 1'b0;
      #2;
      n_cmp += 4;
      if (addr_out !== 32'd0) begin n_bad++; $display("FAIL reset addr_out got=%h want=0", addr_out); end
      if (data_out !== 32'd0) begin n_bad++; $display("FAIL reset data_out got=%h want=0", data_out); end
      if (wr_en !== 1'b0) begin n_bad++; $display("FAIL reset wr_en got=%b want=0", wr_en); end
      if (busy !== 1'b0) begin n_bad++; $display("FAIL reset busy got=%b want=0", busy); end
      repeat (3) @(negedge clk_50);
      rst_n = 1'b1;
      repeat (4) @(negedge clk_50);
      n_cmp += 2;
      if (busy !== 1'b0) begin n_bad++; $display("FAIL reset_idle busy got=%b want=0", busy); end
      if (addr_out !== 32'd0) begin n_bad++; $display("FAIL reset_idle addr got=%h want=0", addr_out); end
   endtask

   task automatic test_single_write();
      int n = 30, pulses = 0;
      set_wave(0, 10, 1'b0); set_wave(10, n, 1'b1);
      for (int c = 0; c < n; c++) swv[c] = 18'h2A5A5;
      run_trace(n);
      for (int c = 0; c < n; c++) begin
         n_cmp += 4;
         if (g_wr[c] !== e_wr[c]) begin n_bad++; $display("FAIL single wr_en cyc=%0d got=%b want=%b", c, g_wr[c], e_wr[c]); end
         if (g_busy[c] !== e_busy[c]) begin n_bad++; $display("FAIL single busy cyc=%0d got=%b want=%b", c, g_busy[c], e_busy[c]); end
         if (g_addr[c] !== e_addr[c]) begin n_bad++; $display("FAIL single addr cyc=%0d got=%h want=%h", c, g_addr[c], e_addr[c]); end
         if (g_data[c] !== e_data[c]) begin n_bad++; $display("FAIL single data cyc=%0d got=%h want=%h", c, g_data[c], e_data[c]); end
         if (g_wr[c]) begin
            pulses++;
            n_cmp += 2;
            if (g_addr[c] !== 32'd0) begin n_bad++; $display("FAIL single pulse_addr got=%h want=0", g_addr[c]); end
            if (g_data[c] !== 32'h0002A5A5) begin n_bad++; $display("FAIL single pulse_data got=%h want=0002a5a5", g_data[c]); end
         end
      end
      n_cmp += 2;
      if (pulses !== 1) begin n_bad++; $display("FAIL single pulse_count got=%0d want=1", pulses); end
      if (g_addr[n-1] !== 32'd1) begin n_bad++; $display("FAIL single final_addr got=%h want=1", g_addr[n-1]); end
   endtask

   task automatic test_short_press();
      int n = 20, pulses = 0;
      int addr_before = m_addr;
      set_wave(0, 2, 1'b0); set_wave(2, n, 1'b1);
      for (int c = 0; c < n; c++) swv[c] = 18'($urandom);
      run_trace(n);
      for (int c = 0; c < n; c++) begin
         n_cmp += 4;
         if (g_wr[c] !== e_wr[c]) begin n_bad++; $display("FAIL short wr_en cyc=%0d got=%b want=%b", c, g_wr[c], e_wr[c]); end
         if (g_busy[c] !== e_busy[c]) begin n_bad++; $display("FAIL short busy cyc=%0d got=%b want=%b", c, g_busy[c], e_busy[c]); end
         if (g_addr[c] !== e_addr[c]) begin n_bad++; $display("FAIL short addr cyc=%0d got=%h want=%h", c, g_addr[c], e_addr[c]); end
         if (g_data[c] !== e_data[c]) begin n_bad++; $display("FAIL short data cyc=%0d got=%h want=%h", c, g_data[c], e_data[c]); end
         if (g_wr[c]) pulses++;
      end
      n_cmp += 3;
      if (pulses !== 0) begin n_bad++; $display("FAIL short pulse_count got=%0d want=0", pulses); end
      if (g_busy[n-1] !== 1'b0) begin n_bad++; $display("FAIL short final_busy got=%b want=0", g_busy[n-1]); end
      if (g_addr[n-1] !== 32'(addr_before)) begin n_bad++; $display("FAIL short final_addr got=%h want=%h", g_addr[n-1], addr_before); end
   endtask

   task automatic test_long_hold();
      int n = 120, pulses = 0;
      set_wave(0, 100, 1'b0); set_wave(100, n, 1'b1);
      for (int c = 0; c < n; c++) swv[c] = 18'($urandom);
      run_trace(n);
      for (int c = 0; c < n; c++) begin
         n_cmp += 4;
         if (g_wr[c] !== e_wr[c]) begin n_bad++; $display("FAIL hold wr_en cyc=%0d got=%b want=%b", c, g_wr[c], e_wr[c]); end
         if (g_busy[c] !== e_busy[c]) begin n_bad++; $display("FAIL hold busy cyc=%0d got=%b want=%b", c, g_busy[c], e_busy[c]); end
         if (g_addr[c] !== e_addr[c]) begin n_bad++; $display("FAIL hold addr cyc=%0d got=%h want=%h", c, g_addr[c], e_addr[c]); end
         if (g_data[c] !== e_data[c]) begin n_bad++; $display("FAIL hold data cyc=%0d got=%h want=%h", c, g_data[c], e_data[c]); end
         if (g_wr[c]) pulses++;
      end
      n_cmp++;
      if (pulses !== 1) begin n_bad++; $display("FAIL hold pulse_count got=%0d want=1", pulses); end
   endtask

   task automatic test_release_bounce();
      int n = 40, pulses = 0;
      int last_low = 12;
      set_wave(0, 10, 1'b0); set_wave(10, 12, 1'b1);
      set_wave(12, 13, 1'b0); set_wave(13, n, 1'b1);
      for (int c = 0; c < n; c++) swv[c] = 18'($urandom);
      run_trace(n);
      for (int c = 0; c < n; c++) begin
         n_cmp += 4;
         if (g_wr[c] !== e_wr[c]) begin n_bad++; $display("FAIL bounce wr_en cyc=%0d got=%b want=%b", c, g_wr[c], e_wr[c]); end
         if (g_busy[c] !== e_busy[c]) begin n_bad++; $display("FAIL bounce busy cyc=%0d got=%b want=%b", c, g_busy[c], e_busy[c]); end
         if (g_addr[c] !== e_addr[c]) begin n_bad++; $display("FAIL bounce addr cyc=%0d got=%h want=%h", c, g_addr[c], e_addr[c]); end
         if (g_data[c] !== e_data[c]) begin n_bad++; $display("FAIL bounce data cyc=%0d got=%h want=%h", c, g_data[c], e_data[c]); end
         if (g_wr[c]) pulses++;
      end
      // Last low reaches the FSM 2 cycles later; then 4 released cycles are counted.
      n_cmp += 3;
      if (pulses !== 1) begin n_bad++; $display("FAIL bounce pulse_count got=%0d want=1", pulses); end
      if (g_busy[last_low+6] !== 1'b1) begin n_bad++; $display("FAIL bounce busy_before_idle got=%b want=1", g_busy[last_low+6]); end
      if (g_busy[last_low+7] !== 1'b0) begin n_bad++; $display("FAIL bounce idle_time got=%b want=0", g_busy[last_low+7]); end
   endtask

   task automatic test_wrap();
      int n = 92, k = 0;
      logic [31:0] exp_seq [5];
      exp_seq = '{32'd0, 32'd1, 32'd2, 32'd3, 32'd0};
      pulse_reset();
      for (int p = 0; p < 5; p++) begin
         set_wave(p*16, p*16 + 8, 1'b0);
         set_wave(p*16 + 8, p*16 + 16, 1'b1);
      end
      set_wave(80, n, 1'b1);
      for (int c = 0; c < n; c++) swv[c] = 18'($urandom);
      run_trace(n);
      for (int c = 0; c < n; c++) begin
         n_cmp += 4;
         if (g_wr[c] !== e_wr[c]) begin n_bad++; $display("FAIL wrap wr_en cyc=%0d got=%b want=%b", c, g_wr[c], e_wr[c]); end
         if (g_busy[c] !== e_busy[c]) begin n_bad++; $display("FAIL wrap busy cyc=%0d got=%b want=%b", c, g_busy[c], e_busy[c]); end
         if (g_addr[c] !== e_addr[c]) begin n_bad++; $display("FAIL wrap addr cyc=%0d got=%h want=%h", c, g_addr[c], e_addr[c]); end
         if (g_data[c] !== e_data[c]) begin n_bad++; $display("FAIL wrap data cyc=%0d got=%h want=%h", c, g_data[c], e_data[c]); end
         if (g_wr[c]) begin
            if (k < 5) begin
               n_cmp++;
               if (g_addr[c] !== exp_seq[k]) begin n_bad++; $display("FAIL wrap seq_addr idx=%0d got=%h want=%h", k, g_addr[c], exp_seq[k]); end
            end
            k++;
         end
      end
      n_cmp++;
      if (k !== 5) begin n_bad++; $display("FAIL wrap pulse_count got=%0d want=5", k); end
   endtask

   task automatic test_random();
      int c = 0, pulses = 0, lo, hi;
      for (int p = 0; p < 6; p++) begin
         lo = $urandom_range(1, 12);
         hi = $urandom_range(1, 8);
         set_wave(c, c + lo, 1'b0); c += lo;
         set_wave(c, c + hi, 1'b1); c += hi;
      end
      set_wave(c, c + 14, 1'b1); c += 14;
      for (int k = 0; k < c; k++) swv[k] = 18'($urandom);
      run_trace(c);
      for (int i = 0; i < c; i++) begin
         n_cmp += 4;
         if (g_wr[i] !== e_wr[i]) begin n_bad++; $display("FAIL random wr_en cyc=%0d got=%b want=%b", i, g_wr[i], e_wr[i]); end
         if (g_busy[i] !== e_busy[i]) begin n_bad++; $display("FAIL random busy cyc=%0d got=%b want=%b", i, g_busy[i], e_busy[i]); end
         if (g_addr[i] !== e_addr[i]) begin n_bad++; $display("FAIL random addr cyc=%0d got=%h want=%h", i, g_addr[i], e_addr[i]); end
         if (g_data[i] !== e_data[i]) begin n_bad++; $display("FAIL random data cyc=%0d got=%h want=%h", i, g_data[i], e_data[i]); end
         if (g_wr[i]) pulses++;
      end
      n_cmp++;
      if (pulses !== e_writes) begin n_bad++; $display("FAIL random pulse_count got=%0d want=%0d", pulses, e_writes); end
   endtask

   task automatic test_reset_in_write();
      logic found = 1'b0;
      @(posedge clk_50); #1;
      write_in = 1'b0;
      sw_in    = 18'h3FFFF;
      for (int i = 0; i < 30 && !found; i++) begin
         @(negedge clk_50);
         if (wr_en) found = 1'b1;
      end
      n_cmp++;
      if (!found) begin
         n_bad++;
         $display("FAIL rst_in_write no wr_en within 30 cycles got=0 want=1");
      end else begin
         rst_n = 1'b0;
         #1;
         n_cmp += 4;
         if (wr_en !== 1'b0) begin n_bad++; $display("FAIL rst_in_write wr_en got=%b want=0", wr_en); end
         if (addr_out !== 32'd0) begin n_bad++; $display("FAIL rst_in_write addr got=%h want=0", addr_out); end
         if (data_out !== 32'd0) begin n_bad++; $display("FAIL rst_in_write data got=%h want=0", data_out); end
         if (busy !== 1'b0) begin n_bad++; $display("FAIL rst_in_write busy got=%b want=0", busy); end
      end
      rst_n    = 1'b0;
      write_in = 1'b1;
      repeat (2) @(negedge clk_50);
      rst_n = 1'b1;
      repeat (4) @(negedge clk_50);
      n_cmp += 3;
      if (addr_out !== 32'd0) begin n_bad++; $display("FAIL rst_after addr got=%h want=0", addr_out); end
      if (busy !== 1'b0) begin n_bad++; $display("FAIL rst_after busy got=%b want=0", busy); end
      if (wr_en !== 1'b0) begin n_bad++; $display("FAIL rst_after wr_en got=%b want=0", wr_en); end
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      test_reset();
      test_single_write();
      test_short_press();
      test_long_hold();
      test_release_bounce();
      test_wrap();
      test_random();
      test_reset_in_write();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
